tdm_mux_8_1_v: RTL and testbench

TDM_MUX_8_1_V -- requirements
Module: tdm_mux_8_1_v

---
 rtl/tdm_mux_8_1_v_if.sv | 34 +++
 rtl/tdm_mux_8_1_v.sv | 98 +++++++++
 tb/tb_tdm_mux_8_1_v.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/tdm_mux_8_1_v_if.sv
// Bus bundle for the 8:1 TDM serializer: load handshake in, serial slot stream out.
// The master drives the load side; the slave is the serializer itself.
interface tdm_mux_8_1_v_if;
    logic [7:0] i_code;
    logic       i_load;
    logic       o_ready;
    logic       o_a;
    logic [7:0] o_sel_code;
    logic       o_valid;
    logic       o_frame;
    logic       o_done;

    modport master (
        output i_code,
        output i_load,
        input  o_ready,
        input  o_a,
        input  o_sel_code,
        input  o_valid,
        input  o_frame,
        input  o_done
    );

    modport slave (
        input  i_code,
        input  i_load,
        output o_ready,
        output o_a,
        output o_sel_code,
        output o_valid,
        output o_frame,
        output o_done
    );
endinterface

// File: rtl/tdm_mux_8_1_v.sv
// 8:1 time-division serializer: a captured byte is emitted LSB first, one channel
// slot of HOLD cycles per bit, with a one-hot channel select beside the data bit.
module tdm_mux_8_1_v #(
    parameter int HOLD = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    tdm_mux_8_1_v_if.slave   bus
);

    localparam logic [3:0] HOLD_LAST = 4'(HOLD - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t     state_reg;
    logic [7:0] word_reg;
    logic [7:0] sel_reg;
    logic [3:0] hold_reg;
    logic       ready_reg;
    logic       a_reg;
    logic       valid_reg;
    logic       frame_reg;
    logic       done_reg;

    logic [7:0] sel_rot;
    logic [3:0] hold_inc;
    logic       slot_end;
    logic       frame_end;

    // Rotate-left of the channel select: channel n hands over to channel n+1.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_rot
            assign sel_rot[gi] = sel_reg[(gi + 7) % 8];
        end
    endgenerate

    assign hold_inc  = hold_reg + 4'd1;
    assign slot_end  = (hold_reg == HOLD_LAST);
    assign frame_end = slot_end & sel_reg[7];

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_reg <= IDLE;
            word_reg  <= 8'h00;
            sel_reg   <= 8'h00;
            hold_reg  <= 4'd0;
            ready_reg <= 1'b1;
            a_reg     <= 1'b0;
            valid_reg <= 1'b0;
            frame_reg <= 1'b0;
            done_reg  <= 1'b0;
        end else if (state_reg == IDLE || frame_end) begin
            // ready_reg is high in both of these cycles, so i_load alone means acceptance.
            if (bus.i_load) begin
                state_reg <= SHIFT;
                word_reg  <= bus.i_code;
                sel_reg   <= 8'h01;
                hold_reg  <= 4'd0;
                ready_reg <= 1'b0;
                a_reg     <= bus.i_code[0];
                valid_reg <= 1'b1;
                frame_reg <= 1'b1;
                done_reg  <= 1'b0;
            end else begin
                state_reg <= IDLE;
                sel_reg   <= 8'h00;
                hold_reg  <= 4'd0;
                ready_reg <= 1'b1;
                a_reg     <= 1'b0;
                valid_reg <= 1'b0;
                frame_reg <= 1'b0;
                done_reg  <= 1'b0;
            end
        end else if (slot_end) begin
            sel_reg   <= sel_rot;
            hold_reg  <= 4'd0;
            a_reg     <= |(word_reg & sel_rot);
            frame_reg <= 1'b0;
            done_reg  <= sel_rot[7] && (HOLD_LAST == 4'd0);
            ready_reg <= sel_rot[7] && (HOLD_LAST == 4'd0);
        end else begin
            hold_reg  <= hold_inc;
            done_reg  <= sel_reg[7] && (hold_inc == HOLD_LAST);
            ready_reg <= sel_reg[7] && (hold_inc == HOLD_LAST);
        end
    end

    assign bus.o_ready    = ready_reg;
    assign bus.o_a        = a_reg;
    assign bus.o_sel_code = sel_reg;
    assign bus.o_valid    = valid_reg;
    assign bus.o_frame    = frame_reg;
    assign bus.o_done     = done_reg;

endmodule

// File: tb/tb_tdm_mux_8_1_v.sv
// Scoreboard bench for tdm_mux_8_1_v: HOLD=1 and HOLD=3 instances exercised in turn,
// expected per-cycle output tuples queued at stimulus time and compared one cycle later.
module tb_tdm_mux_8_1_v;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n1;
    logic rst_n3;

    tdm_mux_8_1_v_if bus1 ();
    tdm_mux_8_1_v_if bus3 ();

    tdm_mux_8_1_v #(.HOLD(1)) dut1 (
        .i_clk   (clk),
        .i_rst_n (rst_n1),
        .bus     (bus1.slave)
    );

    tdm_mux_8_1_v #(.HOLD(3)) dut3 (
        .i_clk   (clk),
        .i_rst_n (rst_n3),
        .bus     (bus3.slave)
    );

    // Tuple layout: {ready, done, frame, valid, a, sel_code[7:0]}
    localparam logic [12:0] IDLE_T = 13'h1000;

    int          checks_cnt = 0;
    int          errors_cnt = 0;
    int          hold_cur   = 1;
    logic        cur_ready  = 1'b1;
    logic [12:0] exp_q[$];
    logic [7:0]  word_q[$];
    logic [7:0]  acc_word   = 8'h00;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s obs=%0h exp=%0h (hold=%0d t=%0t)", tag, obs, exp, hold_cur, $time);
        end
    endtask

    task automatic push_frame(input logic [7:0] code);
        logic [12:0] t;
        logic        d;
        for (int ch = 0; ch < 8; ch++) begin
            for (int k = 0; k < hold_cur; k++) begin
                d = (ch == 7) && (k == hold_cur - 1);
                t = {d, d, (ch == 0), 1'b1, code[ch], 8'(1 << ch)};
                exp_q.push_back(t);
            end
        end
    endtask

    // Drive one cycle of inputs, predict, then observe the cycle after the edge.
    task automatic step(input logic load, input logic [7:0] code, input logic rstn);
        logic [12:0] exp_t;
        logic [12:0] obs_t;
        logic        accepted;
        if (hold_cur == 1) begin
            bus1.i_load = load;
            bus1.i_code = code;
            rst_n1      = rstn;
        end else begin
            bus3.i_load = load;
            bus3.i_code = code;
            rst_n3      = rstn;
        end
        accepted = rstn && load && cur_ready;
        if (!rstn) begin
            exp_q.delete();
            word_q.delete();
            acc_word = 8'h00;
            exp_q.push_back(IDLE_T);
        end else if (accepted) begin
            $display("load hold=%0d word=%02h t=%0t", hold_cur, code, $time);
            push_frame(code);
            word_q.push_back(code);
        end else if (exp_q.size() == 0) begin
            exp_q.push_back(IDLE_T);
        end

        @(posedge clk);
        @(negedge clk);

        exp_t = exp_q.pop_front();
        if (hold_cur == 1)
            obs_t = {bus1.o_ready, bus1.o_done, bus1.o_frame, bus1.o_valid, bus1.o_a, bus1.o_sel_code};
        else
            obs_t = {bus3.o_ready, bus3.o_done, bus3.o_frame, bus3.o_valid, bus3.o_a, bus3.o_sel_code};
        check_eq("cycle", 32'(obs_t), 32'(exp_t));
        cur_ready = exp_t[12];

        // Loopback through a 1:8 demux: the data bit lands on the selected channel line.
        if (obs_t[9]) begin
            check_eq("onehot", 32'($onehot(obs_t[7:0])), 32'd1);
            if (obs_t[8])
                acc_word = acc_word | obs_t[7:0];
            if (obs_t[11]) begin
                if (word_q.size() > 0)
                    check_eq("loopback", 32'(acc_word), 32'(word_q.pop_front()));
                acc_word = 8'h00;
            end
        end
    endtask

    task automatic run_idle(input int n);
        for (int i = 0; i < n; i++)
            step(1'b0, 8'h00, 1'b1);
    endtask

    // Random words loaded back to back, each new load landing in the done cycle.
    task automatic back_to_back(input int n);
        logic [7:0] w;
        for (int i = 0; i < n; i++) begin
            w = 8'($urandom_range(0, 255));
            step(1'b1, w, 1'b1);
            run_idle(8 * hold_cur - 1);
        end
        run_idle(1);
    endtask

    initial begin
        rst_n1      = 1'b0;
        rst_n3      = 1'b0;
        bus1.i_load = 1'b0;
        bus1.i_code = 8'h00;
        bus3.i_load = 1'b0;
        bus3.i_code = 8'h00;

        hold_cur = 1;
        step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b1);

        // A5 single frame, then idle
        step(1'b1, 8'hA5, 1'b1);
        run_idle(8);

        // FF then 00 accepted in the done cycle: 16 contiguous slots
        step(1'b1, 8'hFF, 1'b1);
        run_idle(7);
        step(1'b1, 8'h00, 1'b1);
        run_idle(8);

        // Load while busy is ignored
        step(1'b1, 8'hFF, 1'b1);
        run_idle(3);
        step(1'b1, 8'h00, 1'b1);
        run_idle(4);

        // Reset during channel 3 slot aborts the frame; load under reset ignored
        step(1'b1, 8'h0F, 1'b1);
        run_idle(3);
        step(1'b1, 8'h55, 1'b0);
        run_idle(2);

        back_to_back(4);

        // HOLD=3 instance
        rst_n1      = 1'b1;
        bus1.i_load = 1'b0;
        hold_cur    = 3;
        cur_ready   = 1'b1;
        step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b1);

        step(1'b1, 8'h81, 1'b1);
        run_idle(24);

        back_to_back(3);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
